// File: rtl/dff_pkg.sv
// Shared constants and width helpers for the dff_delay_line pipeline.
// Testbenches import the default WIDTH/DEPTH from here.
package dff_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Width of a stage selector; never narrower than one bit.
    function automatic int tap_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width able to hold the values 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: WIDTH-bit data register plus valid bit.
// With DFF_DELAY_SCAN_EN defined, the data bits also shift as a serial scan segment.
module dff_stage
    import dff_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
`ifdef DFF_DELAY_SCAN_EN
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
`endif
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    // NOTE: every variable gets its hold value first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
`ifdef DFF_DELAY_SCAN_EN
        if (scan_en) begin
            // Bit 0 takes the chain input; the valid bit is outside the chain and holds.
            data_d[0] = scan_in;
            for (int i = 1; i < WIDTH; i++) begin
                data_d[i] = data_q[i-1];
            end
        end else
`endif
        if (flush) begin
            data_d  = '0;
            valid_d = 1'b0;
        end else if (en) begin
            data_d  = d;
            valid_d = d_valid;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q       = data_q;
    assign q_valid = valid_q;
`ifdef DFF_DELAY_SCAN_EN
    assign scan_out = data_q[WIDTH-1];
`endif

endmodule

// File: rtl/dff_delay_line.sv
// WIDTH-bit, DEPTH-stage delay line with enable, flush, valid tracking, tap mux and occupancy count.
// Optional scan chain through all data bits when DFF_DELAY_SCAN_EN is defined.
module dff_delay_line
    import dff_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int TAP_W = tap_w(DEPTH),
    parameter int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [TAP_W-1:0] tap_sel,
`ifdef DFF_DELAY_SCAN_EN
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
`endif
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_last,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] stage_din   [DEPTH];
    logic             stage_vin   [DEPTH];
    logic [WIDTH-1:0] stage_data  [DEPTH];
    logic             stage_valid [DEPTH];
`ifdef DFF_DELAY_SCAN_EN
    logic             stage_sin   [DEPTH];
    logic             stage_sout  [DEPTH];
`endif

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign stage_din[k] = d;
            assign stage_vin[k] = d_valid;
`ifdef DFF_DELAY_SCAN_EN
            assign stage_sin[k] = scan_in;
`endif
        end else begin : g_body
            assign stage_din[k] = stage_data[k-1];
            assign stage_vin[k] = stage_valid[k-1];
`ifdef DFF_DELAY_SCAN_EN
            assign stage_sin[k] = stage_sout[k-1];
`endif
        end

        dff_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .flush   (flush),
            .d       (stage_din[k]),
            .d_valid (stage_vin[k]),
`ifdef DFF_DELAY_SCAN_EN
            .scan_en (scan_en),
            .scan_in (stage_sin[k]),
            .scan_out(stage_sout[k]),
`endif
            .q       (stage_data[k]),
            .q_valid (stage_valid[k])
        );
    end

    // Out-of-range selects (non-power-of-2 DEPTH) fall back to the last stage.
    if (DEPTH == (1 << TAP_W)) begin : g_tap_full
        always_comb begin
            q       = stage_data[tap_sel];
            q_valid = stage_valid[tap_sel];
        end
    end else begin : g_tap_clamp
        always_comb begin
            q       = stage_data[DEPTH-1];
            q_valid = stage_valid[DEPTH-1];
            if (int'(tap_sel) < DEPTH) begin
                q       = stage_data[tap_sel];
                q_valid = stage_valid[tap_sel];
            end
        end
    end

    assign q_last = stage_data[DEPTH-1];

    // Occupancy tracks the valid bits incrementally: one may enter and one may leave per shift.
    logic [CNT_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
`ifdef DFF_DELAY_SCAN_EN
        if (scan_en) begin
            count_d = count_q;
        end else
`endif
        if (flush) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(d_valid) - CNT_W'(stage_valid[DEPTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
`ifdef DFF_DELAY_SCAN_EN
    assign scan_out = stage_sout[DEPTH-1];
`endif

endmodule

// File: tb/tb_dff_delay_line.sv
// Directed bench for dff_delay_line; a queue of shifted-in entries models stage contents.
// Scan checks run only when DFF_DELAY_SCAN_EN is defined.
module tb_dff_delay_line;
    import dff_pkg::*;

    localparam int WIDTH = DEFAULT_WIDTH;
    localparam int DEPTH = DEFAULT_DEPTH;
    localparam int TAP_W = tap_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic [TAP_W-1:0] tap_sel;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [WIDTH-1:0] q_last;
    logic [CNT_W-1:0] count;
`ifdef DFF_DELAY_SCAN_EN
    logic             scan_en;
    logic             scan_in;
    logic             scan_out;
`endif

    int checks   = 0;
    int failures = 0;

    // Scoreboard: back = most recent entry (stage 0); entries leave from the front at q_last.
    logic [WIDTH:0] sb_q [$];

    always #5 clk = ~clk;

    dff_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .d       (d),
        .d_valid (d_valid),
        .tap_sel (tap_sel),
`ifdef DFF_DELAY_SCAN_EN
        .scan_en (scan_en),
        .scan_in (scan_in),
        .scan_out(scan_out),
`endif
        .q       (q),
        .q_valid (q_valid),
        .q_last  (q_last),
        .count   (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH:0] exp_stage(input int k);
        if (k < sb_q.size()) return sb_q[sb_q.size()-1-k];
        return '0;
    endfunction

    function automatic int exp_count();
        int n = 0;
        foreach (sb_q[i]) n += int'(sb_q[i][WIDTH]);
        return n;
    endfunction

    task automatic check_all(input string tag);
        logic [WIDTH:0] e;
        e = exp_stage(int'(tap_sel));
        check({tag, ".q"}, 32'(q), 32'(e[WIDTH-1:0]));
        check({tag, ".q_valid"}, 32'(q_valid), 32'(e[WIDTH]));
        e = exp_stage(DEPTH-1);
        check({tag, ".q_last"}, 32'(q_last), 32'(e[WIDTH-1:0]));
        check({tag, ".count"}, 32'(count), 32'(exp_count()));
    endtask

    // Drive one edge's inputs, advance past the edge and update the scoreboard.
    task automatic tick(input logic en_i, input logic flush_i,
                        input logic [WIDTH-1:0] d_i, input logic dv_i);
        en      = en_i;
        flush   = flush_i;
        d       = d_i;
        d_valid = dv_i;
        @(posedge clk);
        if (flush_i) begin
            sb_q.delete();
        end else if (en_i) begin
            sb_q.push_back({dv_i, d_i});
            if (sb_q.size() > DEPTH) void'(sb_q.pop_front());
        end
        #1;
    endtask

    initial begin
        logic [7:0]  feed [4];
        logic [31:0] pat;
        logic [WIDTH-1:0] exp_b;
        int          bub_cnt [4];
        logic        bub_qv  [4];
        feed    = '{8'h11, 8'h22, 8'h33, 8'h44};
        bub_cnt = '{1, 1, 2, 2};
        bub_qv  = '{1'b0, 1'b1, 1'b0, 1'b1};
        pat     = 32'hA5C3_0F96;

        rst = 1'b1; en = 1'b1; flush = 1'b0; d = 8'hFF; d_valid = 1'b1; tap_sel = '0;
`ifdef DFF_DELAY_SCAN_EN
        scan_en = 1'b0; scan_in = 1'b0;
`endif
        // Reset held while inputs try to load.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_all($sformatf("rst_hold%0d", i));
        end
        rst = 1'b0;

        // Latency: tap 0 shows each value one edge after it is sampled.
        for (int i = 0; i < 4; i++) begin
            tap_sel = '0;
            tick(1'b1, 1'b0, feed[i], 1'b1);
            check($sformatf("lat_tap0_%0d", i), 32'(q), 32'(feed[i]));
            check_all($sformatf("lat%0d", i));
        end
        tap_sel = TAP_W'(3);
        #1;
        check("lat_tap3_q", 32'(q), 32'h11);
        check("lat_q_last", 32'(q_last), 32'h11);
        check("lat_count_full", 32'(count), 32'd4);
        for (int k = 0; k < DEPTH; k++) begin
            tap_sel = TAP_W'(k);
            #1;
            check_all($sformatf("tap%0d", k));
        end

        // Enable low: everything holds while d wanders.
        for (int i = 0; i < 5; i++) begin
            tap_sel = TAP_W'(i % DEPTH);
            tick(1'b0, 1'b0, 8'(8'hC0 + i), i[0]);
            check_all($sformatf("hold%0d", i));
            check($sformatf("hold_last%0d", i), 32'(q_last), 32'h11);
        end

        // Resume: full pipe with valid in and valid out keeps count at 4.
        tap_sel = '0;
        tick(1'b1, 1'b0, 8'h55, 1'b1);
        check_all("resume");
        check("resume_q_last", 32'(q_last), 32'h22);
        check("resume_count", 32'(count), 32'd4);

        // Flush beats enable; AA is not captured.
        tick(1'b1, 1'b1, 8'hAA, 1'b1);
        check_all("flush");
        check("flush_count", 32'(count), 32'd0);
        check("flush_q0", 32'(q), 32'h00);

        // Valid bubbles observed at tap 1.
        tap_sel = TAP_W'(1);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 8'(i + 1), ~i[0]);
            check($sformatf("bub_count%0d", i), 32'(count), 32'(bub_cnt[i]));
            check($sformatf("bub_qv%0d", i), 32'(q_valid), 32'(bub_qv[i]));
            check_all($sformatf("bub%0d", i));
        end

`ifdef DFF_DELAY_SCAN_EN
        // Scan load: en and flush asserted to show scan_en overrides them.
        en = 1'b1; flush = 1'b1; scan_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            scan_in = pat[i];
            @(posedge clk); #1;
        end
        for (int s = 0; s < DEPTH; s++) begin
            tap_sel = TAP_W'(s);
            #1;
            for (int b = 0; b < WIDTH; b++) exp_b[b] = pat[31 - (WIDTH*s + b)];
            check($sformatf("scan_load_s%0d", s), 32'(q), 32'(exp_b));
            check($sformatf("scan_valid_s%0d", s), 32'(q_valid), 32'(exp_stage(s) >> WIDTH));
        end
        check("scan_load_count", 32'(count), 32'(exp_count()));
        scan_in = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check($sformatf("scan_out%0d", i), 32'(scan_out), 32'(pat[i]));
            @(posedge clk); #1;
        end
        check("scan_unload_count", 32'(count), 32'(exp_count()));
        scan_en = 1'b0; flush = 1'b0;
`endif

        // Mid-stream reset acts before the next edge.
        tap_sel = '0;
        tick(1'b1, 1'b0, 8'h77, 1'b1);
        tick(1'b1, 1'b0, 8'h88, 1'b1);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check_all("mid_rst");
        check("mid_rst_count", 32'(count), 32'd0);
        #2;
        rst = 1'b0;
        tick(1'b1, 1'b0, 8'h99, 1'b1);
        check_all("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
